// File: rtl/kpn_pkg.sv
// rtl/kpn_pkg.sv - shared KPN defaults and elaboration-time helpers
package kpn_pkg;

   localparam int KPN_DATA_WIDTH = 16;
   localparam int KPN_FIFO_DEPTH = 8;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/kpn_fifo_mem.sv
// rtl/kpn_fifo_mem.sv - token storage, one write port, one async read port
// Every entry resets to INIT_VALUE; reinit only re-preloads the delay entries.
module kpn_fifo_mem
   import kpn_pkg::*;
#(
   parameter int DATA_WIDTH = KPN_DATA_WIDTH,
   parameter int DEPTH = KPN_FIFO_DEPTH,
   parameter int DELAY_TOKENS = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
   parameter int AW = clog2(DEPTH)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  reinit,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= INIT_VALUE;
         end
      end else if (reinit) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i < DELAY_TOKENS) mem[i] <= INIT_VALUE;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/kpn_delay_fifo.sv
// rtl/kpn_delay_fifo.sv - KPN z^-D delay node built as a preloaded channel FIFO
// Pointers, occupancy, sticky error and accept logic; storage lives in kpn_fifo_mem.
module kpn_delay_fifo
   import kpn_pkg::*;
#(
   parameter int DATA_WIDTH = KPN_DATA_WIDTH,
   parameter int DEPTH = KPN_FIFO_DEPTH,
   parameter int DELAY_TOKENS = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         reinit,
   input  logic                         wr,
   input  logic [DATA_WIDTH-1:0]        entry_1,
   output logic                         full,
   input  logic                         rd,
   output logic [DATA_WIDTH-1:0]        output_1,
   output logic                         empty,
   output logic [clog2(DEPTH+1)-1:0]    count,
   output logic                         err
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = clog2(DEPTH + 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("kpn_delay_fifo: DEPTH must be a power of 2 and >= 2");
   end
   if (DELAY_TOKENS < 0 || DELAY_TOKENS > DEPTH) begin : g_bad_delay
      $error("kpn_delay_fifo: DELAY_TOKENS must be within 0..DEPTH");
   end

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_rd;
   logic          do_wr;

   // Flags come only from the registered count, so rd/wr never reach full/empty combinationally.
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign do_rd = rd & ~empty;
   assign do_wr = wr & (~full | do_rd);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= AW'(DELAY_TOKENS % DEPTH);
         count  <= CW'(DELAY_TOKENS);
         err    <= 1'b0;
      end else if (reinit) begin
         rd_ptr <= '0;
         wr_ptr <= AW'(DELAY_TOKENS % DEPTH);
         count  <= CW'(DELAY_TOKENS);
      end else begin
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_wr & ~do_rd) begin
            count <= count + 1'b1;
         end else if (do_rd & ~do_wr) begin
            count <= count - 1'b1;
         end
         if ((wr & ~do_wr) | (rd & empty)) err <= 1'b1;
      end
   end

   kpn_fifo_mem #(
      .DATA_WIDTH   (DATA_WIDTH),
      .DEPTH        (DEPTH),
      .DELAY_TOKENS (DELAY_TOKENS),
      .INIT_VALUE   (INIT_VALUE),
      .AW           (AW)
   ) u_mem (
      .clk    (clk),
      .rst    (rst),
      .reinit (reinit),
      .we     (do_wr & ~reinit),
      .waddr  (wr_ptr),
      .wdata  (entry_1),
      .raddr  (rd_ptr),
      .rdata  (output_1)
   );

endmodule

// File: tb/tb_kpn_delay_fifo.sv
// tb/tb_kpn_delay_fifo.sv - bench for kpn_delay_fifo, four delay configurations
// Each instance is mirrored by a token queue holding the channel contents.
module tb_kpn_delay_fifo;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic reinit = 1'b0;
   logic [3:0]       wr;
   logic [3:0]       rd;
   logic [3:0]       full;
   logic [3:0]       empty;
   logic [3:0]       err;
   logic [3:0][15:0] din;
   logic [3:0][15:0] dout;
   logic [3:0][3:0]  cnt;

   typedef logic [15:0] tok_q_t [$];
   tok_q_t q [4];
   bit     merr [4];
   bit     wacc [4];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   kpn_delay_fifo #(.DATA_WIDTH(16), .DEPTH(8), .DELAY_TOKENS(2), .INIT_VALUE(16'hFFFF)) u_d2 (
      .clk(clk), .rst(rst), .reinit(reinit), .wr(wr[0]), .entry_1(din[0]), .full(full[0]),
      .rd(rd[0]), .output_1(dout[0]), .empty(empty[0]), .count(cnt[0]), .err(err[0]));
   kpn_delay_fifo #(.DATA_WIDTH(16), .DEPTH(8), .DELAY_TOKENS(0), .INIT_VALUE(16'h0000)) u_d0 (
      .clk(clk), .rst(rst), .reinit(reinit), .wr(wr[1]), .entry_1(din[1]), .full(full[1]),
      .rd(rd[1]), .output_1(dout[1]), .empty(empty[1]), .count(cnt[1]), .err(err[1]));
   kpn_delay_fifo #(.DATA_WIDTH(16), .DEPTH(8), .DELAY_TOKENS(3), .INIT_VALUE(16'h00A5)) u_d3 (
      .clk(clk), .rst(rst), .reinit(reinit), .wr(wr[2]), .entry_1(din[2]), .full(full[2]),
      .rd(rd[2]), .output_1(dout[2]), .empty(empty[2]), .count(cnt[2]), .err(err[2]));
   kpn_delay_fifo #(.DATA_WIDTH(16), .DEPTH(8), .DELAY_TOKENS(8), .INIT_VALUE(16'h1234)) u_d8 (
      .clk(clk), .rst(rst), .reinit(reinit), .wr(wr[3]), .entry_1(din[3]), .full(full[3]),
      .rd(rd[3]), .output_1(dout[3]), .empty(empty[3]), .count(cnt[3]), .err(err[3]));

   function automatic int dt(input int i);
      case (i)
         0: return 2;
         1: return 0;
         2: return 3;
         default: return 8;
      endcase
   endfunction

   function automatic logic [15:0] init_val(input int i);
      case (i)
         0: return 16'hFFFF;
         1: return 16'h0000;
         2: return 16'h00A5;
         default: return 16'h1234;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_preload(input int i);
      q[i].delete();
      for (int k = 0; k < dt(i); k++) q[i].push_back(init_val(i));
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         model_preload(i);
         merr[i] = 1'b0;
         wacc[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit rok, wok;
      for (int i = 0; i < 4; i++) begin
         wacc[i] = 1'b0;
         if (reinit) begin
            model_preload(i);
         end else begin
            rok = rd[i] && (q[i].size() > 0);
            wok = wr[i] && ((q[i].size() < 8) || rok);
            if ((rd[i] && q[i].size() == 0) || (wr[i] && !wok)) merr[i] = 1'b1;
            if (rok) void'(q[i].pop_front());
            if (wok) q[i].push_back(din[i]);
            wacc[i] = wok;
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("count[%0d]", i), 32'(cnt[i]), 32'(q[i].size()));
         check($sformatf("full[%0d]", i), 32'(full[i]), 32'(q[i].size() == 8));
         check($sformatf("empty[%0d]", i), 32'(empty[i]), 32'(q[i].size() == 0));
         check($sformatf("err[%0d]", i), 32'(err[i]), 32'(merr[i]));
         if (q[i].size() > 0) check($sformatf("head[%0d]", i), 32'(dout[i]), 32'(q[i][0]));
      end
   endtask

   task automatic idle();
      wr = '0;
      rd = '0;
      din = '0;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int written;
      int cyc;
      idle();
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      compare_all();

      // reset state
      check("t1_count", 32'(cnt[0]), 32'd2);
      check("t1_out", 32'(dout[0]), 32'hFFFF);
      check("t1_empty", 32'(empty[0]), 32'd0);
      check("t1_full", 32'(full[0]), 32'd0);
      check("t1_err", 32'(err[0]), 32'd0);
      check("t1_d0_empty", 32'(empty[1]), 32'd1);
      check("t1_d0_out", 32'(dout[1]), 32'h0000);
      check("t6_full_at_reset", 32'(full[3]), 32'd1);

      // stream through the two-token delay
      for (int k = 0; k < 12; k++) begin
         wr[0] = (k < 10);
         din[0] = 16'(k + 1);
         rd[0] = 1'b1;
         check("t2_out", 32'(dout[0]), (k < 2) ? 32'hFFFF : 32'(k - 1));
         step();
      end
      idle();
      check("t2_empty", 32'(empty[0]), 32'd1);
      check("t2_count", 32'(cnt[0]), 32'd0);
      check("t2_err", 32'(err[0]), 32'd0);

      // no-delay node: fill, overflow, write-through-while-full
      for (int k = 0; k < 8; k++) begin
         wr[1] = 1'b1;
         din[1] = 16'(16'h100 + k);
         step();
      end
      idle();
      check("t3_full", 32'(full[1]), 32'd1);
      check("t3_count", 32'(cnt[1]), 32'd8);
      wr[1] = 1'b1;
      din[1] = 16'h01FF;
      step();
      idle();
      check("t3_err", 32'(err[1]), 32'd1);
      check("t3_count_drop", 32'(cnt[1]), 32'd8);
      wr[1] = 1'b1;
      rd[1] = 1'b1;
      din[1] = 16'h02AA;
      check("t3_head", 32'(dout[1]), 32'h0100);
      step();
      idle();
      check("t3_count_rw", 32'(cnt[1]), 32'd8);
      for (int k = 0; k < 8; k++) begin
         rd[1] = 1'b1;
         check("t3_drain", 32'(dout[1]), (k < 7) ? 32'(16'h101 + k) : 32'h02AA);
         step();
      end
      idle();

      // randomized traffic with pointer wrap
      written = 0;
      cyc = 0;
      while (written < 40 && cyc < 2000) begin
         rd[2] = ($urandom_range(0, 1) == 1) && (q[2].size() > 0);
         wr[2] = ($urandom_range(0, 2) != 0) && ((q[2].size() < 8) || rd[2]);
         din[2] = 16'($urandom);
         step();
         if (wacc[2]) written++;
         check("t4_cnt_range", 32'(cnt[2] <= 4'd8), 32'd1);
         cyc++;
      end
      idle();
      check("t4_written", 32'(written), 32'd40);
      cyc = 0;
      while (q[2].size() > 0 && cyc < 100) begin
         rd[2] = 1'b1;
         step();
         cyc++;
      end
      idle();
      check("t4_empty", 32'(empty[2]), 32'd1);
      check("t4_err", 32'(err[2]), 32'd0);

      // full-delay node: drain initial tokens then underflow
      for (int k = 0; k < 8; k++) begin
         rd[3] = 1'b1;
         check("t6_out", 32'(dout[3]), 32'h1234);
         step();
      end
      rd[3] = 1'b1;
      step();
      idle();
      check("t6_err", 32'(err[3]), 32'd1);
      check("t6_count", 32'(cnt[3]), 32'd0);

      // asynchronous reset mid-stream, then reinit with err pending
      for (int k = 0; k < 5; k++) begin
         wr[0] = 1'b1;
         din[0] = 16'(16'h50 + k);
         step();
      end
      idle();
      check("t5_count5", 32'(cnt[0]), 32'd5);
      #1 rst = 1'b1;
      model_reset();
      #1;
      check("t5_rst_count", 32'(cnt[0]), 32'd2);
      check("t5_rst_out", 32'(dout[0]), 32'hFFFF);
      check("t5_rst_empty", 32'(empty[0]), 32'd0);
      check("t5_rst_full", 32'(full[0]), 32'd0);
      check("t5_rst_err", 32'(err[0]), 32'd0);
      compare_all();
      #1 rst = 1'b0;
      for (int k = 0; k < 7; k++) begin
         wr[0] = 1'b1;
         din[0] = 16'(16'h60 + k);
         step();
      end
      idle();
      check("t5_err_set", 32'(err[0]), 32'd1);
      reinit = 1'b1;
      wr[0] = 1'b1;
      rd[0] = 1'b1;
      din[0] = 16'hBEEF;
      step();
      reinit = 1'b0;
      idle();
      check("t5_reinit_count", 32'(cnt[0]), 32'd2);
      check("t5_reinit_out", 32'(dout[0]), 32'hFFFF);
      check("t5_reinit_err", 32'(err[0]), 32'd1);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
